// File: rtl/raster_attr_interp.sv
// Two-stage barycentric attribute interpolator with valid/ready flow control.
// S1 registers the weight*attribute products; S2 sums, rounds, shifts and clamps.

module raster_attr_ch #(
  parameter int ATTR_W    = 8,
  parameter int W_WIDTH   = 32,
  parameter int FRAC_BITS = 16,
  parameter int ROUND     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s1_ld,
  input  logic               s2_ld,
  input  logic               flat,
  input  logic [ATTR_W-1:0]  v1,
  input  logic [ATTR_W-1:0]  v2,
  input  logic [ATTR_W-1:0]  v3,
  input  logic [W_WIDTH-1:0] w1,
  input  logic [W_WIDTH-1:0] w2,
  input  logic [W_WIDTH-1:0] w3,
  output logic [ATTR_W-1:0]  attr,
  output logic               sat
);
  localparam int PW = ATTR_W + W_WIDTH + 1;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] RND =
    (ROUND != 0) ? ({{(SW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1)) : '0;
  localparam logic signed [SW-1:0] MAXS = {{(SW-ATTR_W){1'b0}}, {ATTR_W{1'b1}}};

  logic signed [PW-1:0] m1, m2, m3, p1, p2, p3;
  logic        [ATTR_W-1:0] v1_q, clamped;
  logic signed [SW-1:0] sum, shf;
  logic                 clip;

  // Attributes are unsigned: a zero MSB keeps them positive in the signed multiply.
  assign m1 = PW'($signed({1'b0, v1})) * PW'($signed(w1));
  assign m2 = PW'($signed({1'b0, v2})) * PW'($signed(w2));
  assign m3 = PW'($signed({1'b0, v3})) * PW'($signed(w3));

  assign sum = SW'(p1) + SW'(p2) + SW'(p3) + RND;
  assign shf = sum >>> FRAC_BITS;

  always_comb begin
    clamped = shf[ATTR_W-1:0];
    clip    = 1'b0;
    if (shf[SW-1]) begin
      clamped = '0;
      clip    = 1'b1;
    end else if (shf > MAXS) begin
      clamped = '1;
      clip    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0; p2 <= '0; p3 <= '0; v1_q <= '0;
      attr <= '0; sat <= 1'b0;
    end else begin
      if (s1_ld) begin
        p1 <= m1; p2 <= m2; p3 <= m3; v1_q <= v1;
      end
      if (s2_ld) begin
        attr <= flat ? v1_q : clamped;
        sat  <= flat ? 1'b0 : clip;
      end
    end
  end
endmodule

module raster_attr_interp #(
  parameter int NUM_CH    = 3,
  parameter int ATTR_W    = 8,
  parameter int W_WIDTH   = 32,
  parameter int FRAC_BITS = 16,
  parameter int COORD_W   = 16,
  parameter int ROUND     = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [COORD_W-1:0]       i_x,
  input  logic [COORD_W-1:0]       i_y,
  input  logic [W_WIDTH-1:0]       i_w1,
  input  logic [W_WIDTH-1:0]       i_w2,
  input  logic [W_WIDTH-1:0]       i_w3,
  input  logic                     i_flat,
  input  logic [NUM_CH*ATTR_W-1:0] i_v1_attr,
  input  logic [NUM_CH*ATTR_W-1:0] i_v2_attr,
  input  logic [NUM_CH*ATTR_W-1:0] i_v3_attr,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [COORD_W-1:0]       o_x,
  output logic [COORD_W-1:0]       o_y,
  output logic [NUM_CH*ATTR_W-1:0] o_attr,
  output logic [NUM_CH-1:0]        o_sat,
  output logic [31:0]              o_pixel_count
);
  logic s1_valid, s2_valid, s1_adv, s2_adv, s1_ld, s2_ld, s1_flat;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic [NUM_CH-1:0][ATTR_W-1:0] v1_ch, v2_ch, v3_ch, attr_ch;

  // Each stage advances when empty or when the stage ahead is moving.
  assign s2_adv  = !s2_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign s1_ld   = i_valid && s1_adv;
  assign s2_ld   = s1_valid && s2_adv;
  assign o_ready = s1_adv;
  assign o_valid = s2_valid;

  assign v1_ch  = i_v1_attr;
  assign v2_ch  = i_v2_attr;
  assign v3_ch  = i_v3_attr;
  assign o_attr = attr_ch;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    raster_attr_ch #(
      .ATTR_W(ATTR_W), .W_WIDTH(W_WIDTH), .FRAC_BITS(FRAC_BITS), .ROUND(ROUND)
    ) u_ch (
      .clk(i_clk), .rst(i_rst), .s1_ld(s1_ld), .s2_ld(s2_ld), .flat(s1_flat),
      .v1(v1_ch[c]), .v2(v2_ch[c]), .v3(v3_ch[c]),
      .w1(i_w1), .w2(i_w2), .w3(i_w3),
      .attr(attr_ch[c]), .sat(o_sat[c])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0; s2_valid <= 1'b0; s1_flat <= 1'b0;
      s1_x <= '0; s1_y <= '0; o_x <= '0; o_y <= '0;
      o_pixel_count <= '0;
    end else begin
      if (s1_adv) s1_valid <= i_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_ld) begin
        s1_x <= i_x; s1_y <= i_y; s1_flat <= i_flat;
      end
      if (s2_ld) begin
        o_x <= s1_x; o_y <= s1_y;
      end
      if (s2_valid && i_ready) o_pixel_count <= o_pixel_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_raster_attr_interp.sv
// Randomized and directed bench: a queue-based occupancy model predicts ready/valid,
// and an integer reference computes each pixel's attributes for round and truncate builds.

module tb_raster_attr_interp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_valid, i_ready, i_flat;
  logic [15:0] i_x, i_y;
  logic [31:0] i_w1, i_w2, i_w3;
  logic [23:0] v1, v2, v3;

  logic        o_ready, o_valid, o_ready_t, o_valid_t;
  logic [15:0] o_x, o_y, o_x_t, o_y_t;
  logic [23:0] o_attr, o_attr_t;
  logic [2:0]  o_sat, o_sat_t;
  logic [31:0] o_pixel_count, o_pixel_count_t;

  raster_attr_interp #(.NUM_CH(3), .ATTR_W(8), .W_WIDTH(32), .FRAC_BITS(16),
                       .COORD_W(16), .ROUND(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_y(i_y), .i_w1(i_w1), .i_w2(i_w2), .i_w3(i_w3), .i_flat(i_flat),
    .i_v1_attr(v1), .i_v2_attr(v2), .i_v3_attr(v3),
    .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x), .o_y(o_y),
    .o_attr(o_attr), .o_sat(o_sat), .o_pixel_count(o_pixel_count));

  raster_attr_interp #(.NUM_CH(3), .ATTR_W(8), .W_WIDTH(32), .FRAC_BITS(16),
                       .COORD_W(16), .ROUND(0)) u_dut_t (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready_t),
    .i_x(i_x), .i_y(i_y), .i_w1(i_w1), .i_w2(i_w2), .i_w3(i_w3), .i_flat(i_flat),
    .i_v1_attr(v1), .i_v2_attr(v2), .i_v3_attr(v3),
    .o_valid(o_valid_t), .i_ready(i_ready), .o_x(o_x_t), .o_y(o_y_t),
    .o_attr(o_attr_t), .o_sat(o_sat_t), .o_pixel_count(o_pixel_count_t));

  typedef struct {
    logic [15:0] x, y;
    logic [23:0] a1, a0;
    logic [2:0]  s1, s0;
    int          age;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  logic [31:0] cnt;
  int          total = 0, bad = 0;
  logic        acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: weighted sum in 64-bit integers, optional +0.5, floor divide, clamp.
  function automatic void calc(input logic [31:0] w1, w2, w3, input logic f,
                               input logic [23:0] p1, p2, p3, input bit rnd,
                               output logic [23:0] a, output logic [2:0] s);
    a = '0;
    s = '0;
    for (int c = 0; c < 3; c++) begin
      longint t;
      if (f) begin
        a[c*8 +: 8] = p1[c*8 +: 8];
      end else begin
        t = longint'(p1[c*8 +: 8]) * longint'($signed(w1))
          + longint'(p2[c*8 +: 8]) * longint'($signed(w2))
          + longint'(p3[c*8 +: 8]) * longint'($signed(w3));
        if (rnd) t = t + 32768;
        t = t >>> 16;
        if (t < 0) s[c] = 1'b1;
        else if (t > 255) begin a[c*8 +: 8] = 8'hFF; s[c] = 1'b1; end
        else a[c*8 +: 8] = t[7:0];
      end
    end
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    logic rdy_e, vld_e, in_f, out_f;
    exp_t e, n;
    @(negedge clk);
    vld_e = (q.size() > 0) && (q[0].age >= 1);
    rdy_e = !((q.size() == 2) && !i_ready);
    if (vld_e) e = q[0];
    else e = last;
    chk("o_ready", o_ready, rdy_e);
    chk("o_valid", o_valid, vld_e);
    chk("o_ready_t", o_ready_t, rdy_e);
    chk("o_valid_t", o_valid_t, vld_e);
    chk("o_pixel_count", o_pixel_count, cnt);
    chk("o_pixel_count_t", o_pixel_count_t, cnt);
    chk("o_x", o_x, e.x);
    chk("o_y", o_y, e.y);
    chk("o_x_t", o_x_t, e.x);
    chk("o_y_t", o_y_t, e.y);
    chk("o_attr", o_attr, e.a1);
    chk("o_sat", o_sat, e.s1);
    chk("o_attr_t", o_attr_t, e.a0);
    chk("o_sat_t", o_sat_t, e.s0);
    in_f  = i_valid && rdy_e;
    out_f = vld_e && i_ready;
    if (in_f) begin
      n.x = i_x;
      n.y = i_y;
      calc(i_w1, i_w2, i_w3, i_flat, v1, v2, v3, 1'b1, n.a1, n.s1);
      calc(i_w1, i_w2, i_w3, i_flat, v1, v2, v3, 1'b0, n.a0, n.s0);
      n.age = 0;
    end
    @(posedge clk);
    #1;
    if (out_f) begin
      last = q.pop_front();
      cnt  = cnt + 32'd1;
    end
    foreach (q[k]) q[k].age++;
    if (in_f) q.push_back(n);
    acc = in_f;
  endtask

  task automatic drive(input logic [31:0] a, b, c, input logic f,
                       input logic [23:0] p1, p2, p3);
    i_valid = 1'b1;
    i_w1 = a; i_w2 = b; i_w3 = c; i_flat = f;
    v1 = p1; v2 = p2; v3 = p3;
    i_x = 16'($urandom);
    i_y = 16'($urandom);
  endtask

  // Leaves the single pixel sitting in the output stage.
  task automatic send1(input logic [31:0] a, b, c, input logic f,
                       input logic [23:0] p1, p2, p3);
    i_ready = 1'b1;
    drive(a, b, c, f, p1, p2, p3);
    tick();
    i_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    i_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    i_valid = 1'b0;
    q.delete();
    cnt = '0;
    last = '{default: 0};
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_flat = 1'b0;
    i_x = '0; i_y = '0; i_w1 = 32'h10000; i_w2 = '0; i_w3 = '0;
    v1 = 24'h123456; v2 = '0; v3 = '0;
    cnt = '0; acc = 1'b0;
    last = '{default: 0};

    do_reset(2);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_attr", o_attr, 24'h0);
    chk("rst_count", o_pixel_count, 32'h0);
    tick();
    chk("rst_no_capture", o_valid, 1'b0);

    // Identity
    send1(32'h10000, 32'h0, 32'h0, 1'b0, 24'h3264C8, 24'h0, 24'h0);
    chk("id_valid", o_valid, 1'b1);
    chk("id_attr", o_attr, 24'h3264C8);
    chk("id_sat", o_sat, 3'b000);
    tick();
    chk("id_count", o_pixel_count, 32'd1);

    // Rounding: 255 * 0x5555 / 65536 = 84.99
    send1(32'h5555, 32'h5555, 32'h5555, 1'b0, 24'h0000FF, 24'h00FF00, 24'hFF0000);
    chk("rnd_attr", o_attr, 24'h555555);
    chk("trunc_attr", o_attr_t, 24'h545454);
    tick();

    // Saturation high and low
    send1(32'h20000, 32'h0, 32'h0, 1'b0, 24'h0000C8, 24'h0, 24'h0);
    chk("sat_hi_attr", o_attr, 24'h0000FF);
    chk("sat_hi_flag", o_sat, 3'b001);
    tick();
    send1(32'hFFFF8000, 32'h0, 32'h0, 1'b0, 24'h000064, 24'h0, 24'h0);
    chk("sat_lo_attr", o_attr, 24'h000000);
    chk("sat_lo_flag", o_sat, 3'b001);
    tick();

    // Flat shading ignores weights
    send1(32'h0, 32'h10000, 32'h0, 1'b1, 24'h1E140A, 24'h5A5A5A, 24'h0);
    chk("flat_attr", o_attr, 24'h1E140A);
    chk("flat_sat", o_sat, 3'b000);
    chk("flat_attr_t", o_attr_t, 24'h1E140A);
    tick();
    chk("count_5", o_pixel_count, 32'd5);

    // Backpressure: 4 back-to-back pixels, downstream stalled in cycles 3..5
    begin
      int sent = 0;
      for (int c = 1; c <= 16; c++) begin
        i_ready = !(c >= 3 && c <= 5);
        if (sent < 4)
          drive(32'h8000 + 32'(sent) * 32'h1000, 32'h4000, 32'h2000, 1'b0,
                24'($urandom), 24'($urandom), 24'($urandom));
        else i_valid = 1'b0;
        #1;
        if (c == 4) chk("bp_full_ready", o_ready, 1'b0);
        if (c == 4) chk("bp_stall_valid", o_valid, 1'b1);
        tick();
        if (acc) sent++;
      end
      chk("bp_sent", 32'(sent), 32'd4);
      chk("bp_count", o_pixel_count, 32'd9);
    end

    // Random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      drive(32'($urandom_range(0, 163840)) - 32'd32768,
            32'($urandom_range(0, 163840)) - 32'd32768,
            32'($urandom_range(0, 98304)) - 32'd16384,
            ($urandom_range(0, 7) == 0),
            24'($urandom), 24'($urandom), 24'($urandom));
      i_valid = ($urandom_range(0, 2) != 0);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) tick();

    // Reset with both stages full and downstream stalled
    i_ready = 1'b0;
    drive(32'h10000, 32'h0, 32'h0, 1'b0, 24'hAABBCC, 24'h0, 24'h0);
    tick();
    tick();
    chk("mid_full_ready", o_ready, 1'b0);
    do_reset(1);
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_count", o_pixel_count, 32'h0);
    chk("mid_rst_attr", o_attr, 24'h0);
    chk("mid_rst_ready", o_ready, 1'b1);
    send1(32'h10000, 32'h0, 32'h0, 1'b0, 24'h0A0B0C, 24'h0, 24'h0);
    chk("post_rst_attr", o_attr, 24'h0A0B0C);
    tick();
    chk("post_rst_count", o_pixel_count, 32'd1);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
